// File: rtl/id_ex_reg.sv
// ID/EX pipeline register with load-use hazard detection and bubble insertion.
// Each edge performs one action: flush, bubble, or capture, in that priority.
module id_ex_reg #(
   parameter int unsigned DATA_W = 16,
   parameter int unsigned REG_AW = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              id_valid,
   input  logic [4:0]        id_ctrl,
   input  logic [2:0]        id_aluOp,
   input  logic [3:0]        id_funCode,
   input  logic [DATA_W-1:0] id_rd1,
   input  logic [DATA_W-1:0] id_rd2,
   input  logic [DATA_W-1:0] id_imm,
   input  logic [REG_AW-1:0] id_rs,
   input  logic [REG_AW-1:0] id_rt,
   input  logic [REG_AW-1:0] id_rd,
   output logic              ex_valid,
   output logic [4:0]        ex_ctrl,
   output logic [2:0]        ex_aluOp,
   output logic [3:0]        ex_funCode,
   output logic [DATA_W-1:0] ex_rd1,
   output logic [DATA_W-1:0] ex_rd2,
   output logic [DATA_W-1:0] ex_imm,
   output logic [REG_AW-1:0] ex_rs,
   output logic [REG_AW-1:0] ex_rt,
   output logic [REG_AW-1:0] ex_rd,
   output logic              hazard_stall,
   output logic [7:0]        bubble_cnt
);

   // ctrl layout: {regWrite, memRead, memWrite, memToReg, aluSrc}
   localparam int unsigned MemReadBit = 3;

   logic              valid_q,   valid_d;
   logic [4:0]        ctrl_q,    ctrl_d;
   logic [2:0]        alu_op_q,  alu_op_d;
   logic [3:0]        fun_q,     fun_d;
   logic [DATA_W-1:0] rd1_q,     rd1_d;
   logic [DATA_W-1:0] rd2_q,     rd2_d;
   logic [DATA_W-1:0] imm_q,     imm_d;
   logic [REG_AW-1:0] rs_q,      rs_d;
   logic [REG_AW-1:0] rt_q,      rt_d;
   logic [REG_AW-1:0] rd_q,      rd_d;
   logic [7:0]        bubble_cnt_q, bubble_cnt_d;
   logic              stall;

   // Register zero is hardwired, so a load targeting it never creates a dependency.
   assign stall = valid_q & ctrl_q[MemReadBit] & id_valid & (rt_q != '0) &
                  ((rt_q == id_rs) | (rt_q == id_rt));

   always_comb begin
      valid_d      = 1'b0;
      ctrl_d       = '0;
      alu_op_d     = '0;
      fun_d        = '0;
      rd1_d        = '0;
      rd2_d        = '0;
      imm_d        = '0;
      rs_d         = '0;
      rt_d         = '0;
      rd_d         = '0;
      bubble_cnt_d = bubble_cnt_q;
      if (flush) begin
         // zeroed stage already set by defaults
      end else if (stall) begin
         if (bubble_cnt_q != 8'hFF) bubble_cnt_d = bubble_cnt_q + 8'd1;
      end else begin
         valid_d  = id_valid;
         ctrl_d   = id_valid ? id_ctrl : 5'b0;
         alu_op_d = id_aluOp;
         fun_d    = id_funCode;
         rd1_d    = id_rd1;
         rd2_d    = id_rd2;
         imm_d    = id_imm;
         rs_d     = id_rs;
         rt_d     = id_rt;
         rd_d     = id_rd;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         valid_q      <= 1'b0;
         ctrl_q       <= '0;
         alu_op_q     <= '0;
         fun_q        <= '0;
         rd1_q        <= '0;
         rd2_q        <= '0;
         imm_q        <= '0;
         rs_q         <= '0;
         rt_q         <= '0;
         rd_q         <= '0;
         bubble_cnt_q <= '0;
      end else begin
         valid_q      <= valid_d;
         ctrl_q       <= ctrl_d;
         alu_op_q     <= alu_op_d;
         fun_q        <= fun_d;
         rd1_q        <= rd1_d;
         rd2_q        <= rd2_d;
         imm_q        <= imm_d;
         rs_q         <= rs_d;
         rt_q         <= rt_d;
         rd_q         <= rd_d;
         bubble_cnt_q <= bubble_cnt_d;
      end
   end

   assign ex_valid     = valid_q;
   assign ex_ctrl      = ctrl_q;
   assign ex_aluOp     = alu_op_q;
   assign ex_funCode   = fun_q;
   assign ex_rd1       = rd1_q;
   assign ex_rd2       = rd2_q;
   assign ex_imm       = imm_q;
   assign ex_rs        = rs_q;
   assign ex_rt        = rt_q;
   assign ex_rd        = rd_q;
   assign hazard_stall = stall;
   assign bubble_cnt   = bubble_cnt_q;

endmodule

// File: tb/tb_id_ex_reg.sv
// Directed self-checking bench for id_ex_reg: capture, load-use bubbles,
// register-zero, flush priority, counter saturation and asynchronous reset.
module tb_id_ex_reg;

   logic        clk = 1'b0;
   logic        rst;
   logic        flush;
   logic        id_valid;
   logic [4:0]  id_ctrl;
   logic [2:0]  id_aluOp;
   logic [3:0]  id_funCode;
   logic [15:0] id_rd1, id_rd2, id_imm;
   logic [3:0]  id_rs, id_rt, id_rd;
   logic        ex_valid;
   logic [4:0]  ex_ctrl;
   logic [2:0]  ex_aluOp;
   logic [3:0]  ex_funCode;
   logic [15:0] ex_rd1, ex_rd2, ex_imm;
   logic [3:0]  ex_rs, ex_rt, ex_rd;
   logic        hazard_stall;
   logic [7:0]  bubble_cnt;

   int n_tests = 0;
   int n_fail  = 0;

   id_ex_reg #(.DATA_W(16), .REG_AW(4)) dut (
      .clk          (clk),
      .rst          (rst),
      .flush        (flush),
      .id_valid     (id_valid),
      .id_ctrl      (id_ctrl),
      .id_aluOp     (id_aluOp),
      .id_funCode   (id_funCode),
      .id_rd1       (id_rd1),
      .id_rd2       (id_rd2),
      .id_imm       (id_imm),
      .id_rs        (id_rs),
      .id_rt        (id_rt),
      .id_rd        (id_rd),
      .ex_valid     (ex_valid),
      .ex_ctrl      (ex_ctrl),
      .ex_aluOp     (ex_aluOp),
      .ex_funCode   (ex_funCode),
      .ex_rd1       (ex_rd1),
      .ex_rd2       (ex_rd2),
      .ex_imm       (ex_imm),
      .ex_rs        (ex_rs),
      .ex_rt        (ex_rt),
      .ex_rd        (ex_rd),
      .hazard_stall (hazard_stall),
      .bubble_cnt   (bubble_cnt)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_id(input logic v, input logic [4:0] c, input logic [2:0] op,
                         input logic [3:0] fn, input logic [15:0] r1, input logic [15:0] r2,
                         input logic [15:0] im, input logic [3:0] s, input logic [3:0] t,
                         input logic [3:0] d);
      id_valid = v; id_ctrl = c; id_aluOp = op; id_funCode = fn;
      id_rd1 = r1; id_rd2 = r2; id_imm = im; id_rs = s; id_rt = t; id_rd = d;
   endtask

   task automatic test_reset();
      rst = 1'b0;
      flush = 1'b0;
      set_id(1'b1, 5'b11111, 3'b111, 4'hF, 16'hAAAA, 16'h5555, 16'h1111, 4'd1, 4'd2, 4'd3);
      #3;
      n_tests++;
      if ({ex_valid, ex_ctrl, ex_aluOp, ex_funCode, ex_rd1, ex_rd2, ex_imm, ex_rs, ex_rt, ex_rd}
          !== '0) begin
         n_fail++; $display("FAIL reset_fields: got nonzero ex_ state, want all 0");
      end
      n_tests++;
      if (bubble_cnt !== 8'd0) begin
         n_fail++; $display("FAIL reset_cnt: got %0d want 0", bubble_cnt);
      end
      tick();  // rst still low: no capture
      n_tests++;
      if (ex_valid !== 1'b0 || ex_rd1 !== 16'h0) begin
         n_fail++; $display("FAIL reset_hold: got valid=%b rd1=%h want 0/0000", ex_valid, ex_rd1);
      end
      #2 rst = 1'b1;
   endtask

   task automatic test_capture();
      set_id(1'b1, 5'b10001, 3'b000, 4'b0101, 16'h1234, 16'hBEEF, 16'hFFF0, 4'd2, 4'd3, 4'd7);
      tick();
      n_tests++;
      if (ex_valid !== 1'b1 || ex_ctrl !== 5'b10001 || ex_aluOp !== 3'b000 ||
          ex_funCode !== 4'b0101) begin
         n_fail++; $display("FAIL capture_ctrl: got v=%b c=%b op=%b fn=%b want 1 10001 000 0101",
                            ex_valid, ex_ctrl, ex_aluOp, ex_funCode);
      end
      n_tests++;
      if (ex_rd1 !== 16'h1234 || ex_rd2 !== 16'hBEEF || ex_imm !== 16'hFFF0) begin
         n_fail++; $display("FAIL capture_data: got %h %h %h want 1234 beef fff0",
                            ex_rd1, ex_rd2, ex_imm);
      end
      n_tests++;
      if (ex_rs !== 4'd2 || ex_rt !== 4'd3 || ex_rd !== 4'd7) begin
         n_fail++; $display("FAIL capture_regs: got %0d %0d %0d want 2 3 7", ex_rs, ex_rt, ex_rd);
      end
      // undefined ALU op passes through untouched
      set_id(1'b1, 5'b00001, 3'b111, 4'b1010, 16'h0F0F, 16'h0001, 16'h0002, 4'd4, 4'd5, 4'd6);
      tick();
      n_tests++;
      if (ex_aluOp !== 3'b111 || ex_funCode !== 4'b1010 || ex_ctrl !== 5'b00001) begin
         n_fail++; $display("FAIL capture_aluop: got op=%b fn=%b c=%b want 111 1010 00001",
                            ex_aluOp, ex_funCode, ex_ctrl);
      end
      // invalid instruction: fields load, ctrl forced to zero
      set_id(1'b0, 5'b11111, 3'b010, 4'b0011, 16'hCAFE, 16'h0BAD, 16'h7777, 4'd8, 4'd9, 4'd10);
      tick();
      n_tests++;
      if (ex_valid !== 1'b0 || ex_ctrl !== 5'b00000 || ex_rd1 !== 16'hCAFE ||
          ex_rd !== 4'd10 || ex_aluOp !== 3'b010) begin
         n_fail++; $display("FAIL capture_invalid: got v=%b c=%b rd1=%h rd=%0d op=%b want 0 0 cafe 10 010",
                            ex_valid, ex_ctrl, ex_rd1, ex_rd, ex_aluOp);
      end
   endtask

   task automatic test_load_use();
      set_id(1'b1, 5'b11010, 3'b000, 4'b0000, 16'h0100, 16'h0000, 16'h0004, 4'd1, 4'd5, 4'd0);
      tick();
      set_id(1'b1, 5'b10000, 3'b010, 4'b0110, 16'h2222, 16'h3333, 16'h0000, 4'd5, 4'd6, 4'd9);
      #1;
      n_tests++;
      if (hazard_stall !== 1'b1) begin
         n_fail++; $display("FAIL loaduse_stall: got %b want 1", hazard_stall);
      end
      tick();
      n_tests++;
      if (ex_valid !== 1'b0 || ex_ctrl !== 5'b0 || ex_aluOp !== 3'b000 || ex_funCode !== 4'b0 ||
          ex_rd1 !== 16'h0 || ex_rt !== 4'd0) begin
         n_fail++; $display("FAIL loaduse_bubble: got v=%b c=%b op=%b fn=%b rd1=%h rt=%0d want zeros",
                            ex_valid, ex_ctrl, ex_aluOp, ex_funCode, ex_rd1, ex_rt);
      end
      n_tests++;
      if (bubble_cnt !== 8'd1 || hazard_stall !== 1'b0) begin
         n_fail++; $display("FAIL loaduse_cnt: got cnt=%0d stall=%b want 1 0", bubble_cnt, hazard_stall);
      end
      tick();
      n_tests++;
      if (ex_valid !== 1'b1 || ex_rs !== 4'd5 || ex_rd1 !== 16'h2222 || bubble_cnt !== 8'd1) begin
         n_fail++; $display("FAIL loaduse_resume: got v=%b rs=%0d rd1=%h cnt=%0d want 1 5 2222 1",
                            ex_valid, ex_rs, ex_rd1, bubble_cnt);
      end
   endtask

   task automatic test_reg_zero();
      set_id(1'b1, 5'b11010, 3'b000, 4'b0000, 16'h0000, 16'h0000, 16'h0008, 4'd3, 4'd0, 4'd0);
      tick();
      set_id(1'b1, 5'b10000, 3'b011, 4'b0001, 16'h4444, 16'h5555, 16'h0000, 4'd0, 4'd0, 4'd12);
      #1;
      n_tests++;
      if (hazard_stall !== 1'b0) begin
         n_fail++; $display("FAIL regzero_stall: got %b want 0", hazard_stall);
      end
      tick();
      n_tests++;
      if (ex_valid !== 1'b1 || ex_rd !== 4'd12 || ex_rd1 !== 16'h4444 || bubble_cnt !== 8'd1) begin
         n_fail++; $display("FAIL regzero_capture: got v=%b rd=%0d rd1=%h cnt=%0d want 1 12 4444 1",
                            ex_valid, ex_rd, ex_rd1, bubble_cnt);
      end
   endtask

   task automatic test_flush_hazard();
      set_id(1'b1, 5'b11010, 3'b000, 4'b0000, 16'h0000, 16'h0000, 16'h0000, 4'd2, 4'd4, 4'd0);
      tick();
      set_id(1'b1, 5'b10001, 3'b100, 4'b0111, 16'h6666, 16'h7777, 16'h8888, 4'd4, 4'd1, 4'd13);
      flush = 1'b1;
      #1;
      n_tests++;
      if (hazard_stall !== 1'b1) begin
         n_fail++; $display("FAIL flush_hazard_stall: got %b want 1", hazard_stall);
      end
      tick();
      flush = 1'b0;
      n_tests++;
      if ({ex_valid, ex_ctrl, ex_aluOp, ex_funCode, ex_rd1, ex_rd2, ex_imm, ex_rs, ex_rt, ex_rd}
          !== '0) begin
         n_fail++; $display("FAIL flush_zero: got v=%b c=%b rd1=%h want all 0", ex_valid, ex_ctrl, ex_rd1);
      end
      n_tests++;
      if (bubble_cnt !== 8'd1) begin
         n_fail++; $display("FAIL flush_cnt: got %0d want 1", bubble_cnt);
      end
   endtask

   task automatic test_saturation();
      int bubbles = 0;
      int cycles  = 0;
      int exp_cnt = 1;
      logic prev_stall = 1'b0;
      logic stall_now;
      // constant dependent load: stage alternates capture / bubble
      set_id(1'b1, 5'b11010, 3'b000, 4'b0000, 16'h0000, 16'h0000, 16'h0000, 4'd5, 4'd5, 4'd5);
      while (bubbles < 260 && cycles < 1200) begin
         #1;
         stall_now = hazard_stall;
         if (prev_stall && stall_now) begin
            n_tests++; n_fail++;
            $display("FAIL sat_double_stall: got two stall cycles in a row at cycle %0d", cycles);
         end
         prev_stall = stall_now;
         tick();
         cycles++;
         if (stall_now) begin
            bubbles++;
            if (exp_cnt < 255) exp_cnt++;
            if (bubbles == 254 || bubbles == 255 || bubbles == 260) begin
               n_tests++;
               if (bubble_cnt !== exp_cnt[7:0]) begin
                  n_fail++; $display("FAIL sat_cnt: after %0d bubbles got %0d want %0d",
                                     bubbles, bubble_cnt, exp_cnt);
               end
            end
         end
      end
      n_tests++;
      if (bubbles < 260) begin
         n_fail++; $display("FAIL sat_timeout: got %0d bubbles want 260", bubbles);
      end
      n_tests++;
      if (bubble_cnt !== 8'd255) begin
         n_fail++; $display("FAIL sat_final: got %0d want 255", bubble_cnt);
      end
   endtask

   task automatic test_async_reset();
      set_id(1'b1, 5'b10001, 3'b010, 4'b0010, 16'h9ABC, 16'hDEF0, 16'h0042, 4'd1, 4'd2, 4'd3);
      tick();
      n_tests++;
      if (ex_valid !== 1'b1 || ex_rd1 !== 16'h9ABC) begin
         n_fail++; $display("FAIL areset_pre: got v=%b rd1=%h want 1 9abc", ex_valid, ex_rd1);
      end
      #2 rst = 1'b0;
      #1;
      n_tests++;
      if ({ex_valid, ex_ctrl, ex_aluOp, ex_funCode, ex_rd1, ex_rd2, ex_imm, ex_rs, ex_rt, ex_rd}
          !== '0 || bubble_cnt !== 8'd0) begin
         n_fail++; $display("FAIL areset_async: got v=%b rd1=%h cnt=%0d want 0 0000 0",
                            ex_valid, ex_rd1, bubble_cnt);
      end
      tick();
      #2 rst = 1'b1;
      set_id(1'b1, 5'b10100, 3'b011, 4'b1001, 16'h1357, 16'h2468, 16'h0FF0, 4'd6, 4'd7, 4'd8);
      tick();
      n_tests++;
      if (ex_valid !== 1'b1 || ex_ctrl !== 5'b10100 || ex_rd1 !== 16'h1357 ||
          ex_rd !== 4'd8 || bubble_cnt !== 8'd0) begin
         n_fail++; $display("FAIL areset_recapture: got v=%b c=%b rd1=%h rd=%0d cnt=%0d want 1 10100 1357 8 0",
                            ex_valid, ex_ctrl, ex_rd1, ex_rd, bubble_cnt);
      end
   endtask

   initial begin
      test_reset();
      test_capture();
      test_load_use();
      test_reg_zero();
      test_flush_hazard();
      test_saturation();
      test_async_reset();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/id_ex_reg.md
ID_EX_REG -- requirements
Module: id_ex_reg

Interface
REQ-001 Parameter DATA_W, default 16, width of operand and immediate fields.
REQ-002 Parameter REG_AW, default 4, width of register-specifier fields.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low (0 = reset).
REQ-005 flush  input  1  branch/jump flush request from ID control.
REQ-006 id_valid  input  1  ID stage holds a real instruction.
REQ-007 id_ctrl  input  5  {regWrite, memRead, memWrite, memToReg, aluSrc}.
REQ-008 id_aluOp  input  3  ALU operation class for EX ALU control.
REQ-009 id_funCode  input  4  R-type function code.
REQ-010 id_rd1, id_rd2  input  DATA_W each  register-file read data.
REQ-011 id_imm  input  DATA_W  sign-extended immediate.
REQ-012 id_rs, id_rt, id_rd  input  REG_AW each  register specifiers.
REQ-013 ex_valid, ex_ctrl, ex_aluOp, ex_funCode, ex_rd1, ex_rd2, ex_imm, ex_rs, ex_rt, ex_rd  output  widths as id_ counterparts  registered EX-stage copies.
REQ-014 hazard_stall  output  1  combinational load-use stall to PC and IF/ID (hold).
REQ-015 bubble_cnt  output  8  saturating count of hazard bubbles inserted.

Function
REQ-016 hazard_stall SHALL = ex_valid & ex_ctrl.memRead & id_valid & (ex_rt != 0) & ((ex_rt == id_rs) | (ex_rt == id_rt)); register 0 never causes a stall.
REQ-017 Each rising edge SHALL perform exactly one of: FLUSH, BUBBLE, CAPTURE, priority FLUSH > BUBBLE > CAPTURE.
REQ-018 FLUSH (flush=1): all ex_ outputs SHALL become 0 next cycle regardless of hazard_stall; bubble_cnt unchanged.
REQ-019 BUBBLE (flush=0, hazard_stall=1): all ex_ outputs SHALL become 0; bubble_cnt SHALL increment by 1, saturating at 255 (no wrap).
REQ-020 CAPTURE (otherwise): every ex_ field SHALL load its id_ counterpart, ex_valid <= id_valid, latency exactly 1 cycle.
REQ-021 CAPTURE with id_valid=0 SHALL still load all fields but ex_ctrl SHALL be forced to 0 so no side effects leave EX.
REQ-022 id_aluOp values outside {000,010,011,100} SHALL pass through unmodified; decoding is EX's responsibility.
REQ-023 A zeroed stage (bubble) SHALL present ex_aluOp=000, ex_funCode=0000, i.e. a harmless add.
REQ-024 After a BUBBLE, ex_valid=0 so hazard_stall SHALL deassert; one load produces at most one consecutive stall cycle.
REQ-025 No output other than hazard_stall SHALL change except on a rising clk edge or reset assertion.

Reset
REQ-026 rst=0 SHALL immediately, without clk, drive all ex_ outputs and bubble_cnt to 0; hazard_stall therefore 0.
REQ-027 Reset asserted mid-operation SHALL discard the in-flight instruction; first edge after rst returns to 1 SHALL follow REQ-017 normally.
REQ-028 rst release SHALL be sampled synchronously; no capture occurs on the edge coincident with release if rst still low at that edge.

Verification
REQ-029 CAPTURE: id_valid=1, id_ctrl=10001, id_aluOp=000, id_funCode=0101, id_rd1=0x1234, id_rt=3 -> next cycle ex_ fields identical, ex_valid=1.
REQ-030 Load-use: EX holds memRead load with ex_rt=5, ID instruction id_rs=5 -> hazard_stall=1 same cycle; next cycle ex_valid=0, ex_ctrl=0, bubble_cnt=1, hazard_stall=0.
REQ-031 Register zero: EX load ex_rt=0, id_rs=0 -> hazard_stall=0, capture proceeds, bubble_cnt unchanged.
REQ-032 Simultaneous flush and hazard -> next cycle all ex_ zero, bubble_cnt unchanged.
REQ-033 Saturation: force 260 hazard bubbles -> bubble_cnt reads 255 after the 255th and stays 255.
REQ-034 Async reset: populated stage, drop rst between edges -> ex_ outputs and bubble_cnt 0 before next edge; after release a CAPTURE loads normally.
